arb_video_port: RTL and testbench
=================================

// Module: arb_video_port
// PURPOSE
//  Responder end of the memory-arbiter video port: slots DRAM cycles between video fetch and CPU.
//  Grants video cycles at the requested bandwidth, issues the DRAM reads, and returns the data.
//  Handshake to the video side is video_next (address taken) then video_strobe (data valid).
//  The leftover slots go to the CPU client.
// PARAMETERS
//  ADDR_W   21   DRAM word address width (video_addr / cpu_addr)
//  DATA_W   16   DRAM data width
// PORTS
//  clk            in   1       28 MHz system clock
//  rst_n          in   1       asynchronous, active-low reset
//  cbeg,post_cbeg in   1       memory-cycle phase strobes (one clk each, 4-clk cycle)
//  pre_cend,cend  in   1       pre_cend precedes cend by 1 clk
//  video_go       in   1       video side requests fetching this cycle
//  video_bw       in   2       00=1/8, 01=2/8, 10=4/8, 11=reserved (treated as 4/8)
//  video_addr     in   ADDR_W  word address of next video fetch
//  video_next     out  1       1-clk pulse: video_addr consumed, advance address
//  video_strobe   out  1       1-clk pulse: video_data valid
//  video_data     out  DATA_W  fetched word, held until next strobe
//  cpu_req        in   1       CPU access request (level, held until cpu_next)
//  cpu_rnw        in   1       1=read, 0=write
//  cpu_addr       in   ADDR_W  CPU word address
//  cpu_wrdata     in   DATA_W  CPU write data
//  cpu_next       out  1       1-clk pulse: CPU request accepted
//  cpu_strobe     out  1       1-clk pulse: cpu_rddata valid (reads only)
//  cpu_rddata     out  DATA_W  CPU read data
//  dram_req       out  1       1-clk pulse at cend: start DRAM cycle
//  dram_rnw       out  1       direction of started cycle
//  dram_addr      out  ADDR_W  address of started cycle
//  dram_wrdata    out  DATA_W  write data of started cycle
//  dram_rddata    in   DATA_W  read data, valid on pre_cend of the started cycle
// BEHAVIOUR
//  - Reset: all outputs 0, slot counter 0, owner=NONE. Reset mid-cycle abandons the pending read; no strobe follows.
//  - slot[2:0] increments on every cend (wraps 7->0).
//  - Video-eligible slot by bw:
//    - 1/8: slot==0.
//    - 2/8: slot[1:0]==0.
//    - 4/8/11: slot[0]==0.
//  - Decision at each cend:
//    - if eligible && video_go: owner<=VIDEO; video_next=1; dram_req=1; dram_addr=video_addr; dram_rnw=1.
//    - else if cpu_req && (!eligible || borrow allowed): owner<=CPU; cpu_next=1; dram_req=1 with cpu fields.
//    - else owner<=NONE, no dram_req.
//  - Video wins over CPU on simultaneous request in an eligible slot.
//  - On pre_cend of the following cycle:
//    - owner VIDEO: capture dram_rddata into video_data, pulse video_strobe on next clk (coincides with cend).
//    - owner CPU read: same via cpu_rddata/cpu_strobe.
//    - CPU write: no strobe.
//  - Latency: video_next -> video_strobe = 4 clks (one memory cycle); back-to-back grants pipeline, one per cycle max.
//  - video_bw / video_go sampled only at cend; mid-cycle changes affect the next decision only.
//  - video_go dropping after grant does not cancel the in-flight read (strobe still issued).
// CONFIGURATION
//  ARB_CPU_BORROW_EN defined:
//    - CPU may use a video-eligible slot when video_go is low at that cend.
//  Undefined:
//    - Eligible slots are reserved for video; they idle (no dram_req) when video_go is low.
// STRUCTURE
//  Shared package/include (arb_defs):
//    - owner encoding NONE/VIDEO/CPU.
//    - bw codes BW_1_8/BW_2_8/BW_4_8.
//  One sub-module arb_slot_sched: slot counter + eligibility decode (clk, rst_n, cend, video_bw -> eligible).
//  Data path and handshake stay in top.
// TESTING
//  1. bw=00, go=1 for 16 cycles, no cpu
//     -> exactly 2 video_next (slots 0), each followed by video_strobe 4 clks later with DRAM model data.
//  2. bw=10, go=1, cpu_req held
//     -> video on even slots, cpu_next on odd slots; 4 video + 4 cpu per 8 cycles.
//  3. bw=01, go=0, cpu_req=1
//     -> with ARB_CPU_BORROW_EN: cpu_next every cycle; without: no cpu_next on slots 0,4.
//  4. CPU write addr=0x1F000 data=0xA55A in non-eligible slot
//     -> dram_req with rnw=0, addr/data match, no cpu_strobe.
//  5. rst_n low 2 clks between video_next and pre_cend
//     -> no video_strobe, outputs 0, slot restarts at 0.
//  6. go falls the clk after video_next -> video_strobe still pulses once with captured data.

Source files
------------

// File: rtl/arb_video_port_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | arb_video_port_pkg: owner encoding, bandwidth codes and slot eligibility     |
// | decode shared by the video-port arbiter.                                     |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
package arb_video_port_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_VIDEO = 2'd1,
        OWNER_CPU   = 2'd2
    } owner_e;

    localparam logic [1:0] BW_1_8 = 2'b00;
    localparam logic [1:0] BW_2_8 = 2'b01;
    localparam logic [1:0] BW_4_8 = 2'b10;

    localparam int SLOT_W = 3;

    // Code 2'b11 is reserved and behaves as 4/8.
    function automatic logic slot_eligible(input logic [1:0] bw, input logic [SLOT_W-1:0] slot);
        logic elig;
        case (bw)
            BW_1_8:  elig = (slot == '0);
            BW_2_8:  elig = (slot[1:0] == 2'b00);
            BW_4_8:  elig = ~slot[0];
            default: elig = ~slot[0];
        endcase
        return elig;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_video_port_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | arb_video_port_if: phase strobes, video/CPU client and DRAM signals of the   |
// | video-port arbiter. slave = arbiter side, master = clients/DRAM side.        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface arb_video_port_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
);
    logic              cbeg;
    logic              post_cbeg;
    logic              pre_cend;
    logic              cend;

    logic              video_go;
    logic [1:0]        video_bw;
    logic [ADDR_W-1:0] video_addr;
    logic              video_next;
    logic              video_strobe;
    logic [DATA_W-1:0] video_data;

    logic              cpu_req;
    logic              cpu_rnw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wrdata;
    logic              cpu_next;
    logic              cpu_strobe;
    logic [DATA_W-1:0] cpu_rddata;

    logic              dram_req;
    logic              dram_rnw;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wrdata;
    logic [DATA_W-1:0] dram_rddata;

    modport slave (
        input  cbeg, post_cbeg, pre_cend, cend,
        input  video_go, video_bw, video_addr,
        output video_next, video_strobe, video_data,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata,
        output cpu_next, cpu_strobe, cpu_rddata,
        output dram_req, dram_rnw, dram_addr, dram_wrdata,
        input  dram_rddata
    );

    modport master (
        output cbeg, post_cbeg, pre_cend, cend,
        output video_go, video_bw, video_addr,
        input  video_next, video_strobe, video_data,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata,
        input  cpu_next, cpu_strobe, cpu_rddata,
        input  dram_req, dram_rnw, dram_addr, dram_wrdata,
        output dram_rddata
    );

endinterface
`default_nettype wire

// File: rtl/arb_video_port_slot_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | arb_slot_sched: 3-bit memory-cycle slot counter advanced on each cend, and   |
// | decode of whether the current slot is reserved for video fetch.              |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module arb_slot_sched
    import arb_video_port_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cend,
    input  logic [1:0] video_bw,
    output logic       eligible
);

    logic [SLOT_W-1:0] slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (cend) begin
            slot <= slot + 1'b1;
        end
    end

    assign eligible = slot_eligible(video_bw, slot);

endmodule
`default_nettype wire

// File: rtl/arb_video_port.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | arb_video_port: slots DRAM cycles between video fetch and CPU, issues the    |
// | DRAM cycle at cend and returns read data one memory cycle later.             |
// | Option macro ARB_CPU_BORROW_EN: CPU may take idle video-eligible slots.      |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module arb_video_port
    import arb_video_port_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    arb_video_port_if.slave  bus
);

`ifdef ARB_CPU_BORROW_EN
    localparam logic BORROW_EN = 1'b1;
`else
    localparam logic BORROW_EN = 1'b0;
`endif

    logic              running;
    logic              cycle_end;
    logic              eligible;
    logic              grant_video;
    logic              grant_cpu;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wrdata;

    owner_e            owner;
    owner_e            owner_nx;
    logic              cpu_read;
    logic              cpu_read_nx;

    logic              video_strobe_r;
    logic [DATA_W-1:0] video_data_r;
    logic              cpu_strobe_r;
    logic [DATA_W-1:0] cpu_rddata_r;

    // Arbitration starts only once a fresh memory cycle is seen after reset,
    // so a reset released late in a cycle never grants on a partial cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else if (bus.cbeg || bus.post_cbeg) begin
            running <= 1'b1;
        end
    end

    assign cycle_end = bus.cend & running;

    arb_slot_sched u_slot_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .cend     (cycle_end),
        .video_bw (bus.video_bw),
        .eligible (eligible)
    );

    assign grant_video = cycle_end & eligible & bus.video_go;
    assign grant_cpu   = cycle_end & ~grant_video & bus.cpu_req
                       & (~eligible | (BORROW_EN & ~bus.video_go));

    always_comb begin
        grant_addr   = '0;
        grant_wrdata = '0;
        if (grant_video) begin
            grant_addr = bus.video_addr;
        end else if (grant_cpu) begin
            grant_addr = bus.cpu_addr;
            if (!bus.cpu_rnw) begin
                grant_wrdata = bus.cpu_wrdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWNER_NONE;
            cpu_read <= 1'b0;
        end else begin
            owner    <= owner_nx;
            cpu_read <= cpu_read_nx;
        end
    end

    // Owner of the DRAM cycle in flight; cleared once its data is taken at pre_cend.
    always_comb begin
        owner_nx    = owner;
        cpu_read_nx = cpu_read;
        if (cycle_end) begin
            if (grant_video) begin
                owner_nx = OWNER_VIDEO;
            end else if (grant_cpu) begin
                owner_nx = OWNER_CPU;
            end else begin
                owner_nx = OWNER_NONE;
            end
            cpu_read_nx = grant_cpu & bus.cpu_rnw;
        end else if (bus.pre_cend) begin
            owner_nx    = OWNER_NONE;
            cpu_read_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_strobe_r <= 1'b0;
            video_data_r   <= '0;
            cpu_strobe_r   <= 1'b0;
            cpu_rddata_r   <= '0;
        end else begin
            video_strobe_r <= bus.pre_cend && (owner == OWNER_VIDEO);
            cpu_strobe_r   <= bus.pre_cend && (owner == OWNER_CPU) && cpu_read;
            if (bus.pre_cend && (owner == OWNER_VIDEO)) begin
                video_data_r <= bus.dram_rddata;
            end
            if (bus.pre_cend && (owner == OWNER_CPU) && cpu_read) begin
                cpu_rddata_r <= bus.dram_rddata;
            end
        end
    end

    assign bus.video_next   = grant_video;
    assign bus.video_strobe = video_strobe_r;
    assign bus.video_data   = video_data_r;
    assign bus.cpu_next     = grant_cpu;
    assign bus.cpu_strobe   = cpu_strobe_r;
    assign bus.cpu_rddata   = cpu_rddata_r;
    assign bus.dram_req     = grant_video | grant_cpu;
    assign bus.dram_rnw     = grant_video | (grant_cpu & bus.cpu_rnw);
    assign bus.dram_addr    = grant_addr;
    assign bus.dram_wrdata  = grant_wrdata;

endmodule
`default_nettype wire

// File: tb/tb_arb_video_port.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_arb_video_port: directed bench for arb_video_port with a DRAM model and   |
// | per-grant latency/data scoreboard.                                           |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_arb_video_port;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arb_video_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    arb_video_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Values the clients want on the next clock; applied just after each edge.
    logic              rst_s;
    logic              go_s;
    logic [1:0]        bw_s;
    logic [ADDR_W-1:0] vaddr_s;
    logic              creq_s;
    logic              crnw_s;
    logic [ADDR_W-1:0] caddr_s;
    logic [DATA_W-1:0] cwdata_s;

    int ph = 3;
    int nclk = 0;
    int cend_idx = 0;
    int n_vnext = 0, n_cnext = 0, n_vstb = 0, n_cstb = 0, n_dreq = 0, n_bad = 0;
    int last_vnext_clk = -100, last_cnext_clk = -100;
    logic [DATA_W-1:0] exp_vdata = '0, exp_cdata = '0;
    int errors = 0, checks = 0;

    function automatic logic [DATA_W-1:0] model(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    function automatic bit elig(input logic [1:0] bw, input int idx);
        int s;
        if (idx < 0) return 1'b0;
        s = idx % 8;
        case (bw)
            2'b00:   return s == 0;
            2'b01:   return (s % 4) == 0;
            default: return (s % 2) == 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic              rq;
        logic [ADDR_W-1:0] ra;
        rq = bus.dram_req;
        ra = bus.dram_addr;
        @(posedge clk);
        if (rq) bus.dram_rddata = model(ra);
        #1;
        ph = (ph + 1) % 4;
        bus.cbeg       = (ph == 0);
        bus.post_cbeg  = (ph == 1);
        bus.pre_cend   = (ph == 2);
        bus.cend       = (ph == 3);
        rst_n          = rst_s;
        bus.video_go   = go_s;
        bus.video_bw   = bw_s;
        bus.video_addr = vaddr_s;
        bus.cpu_req    = creq_s;
        bus.cpu_rnw    = crnw_s;
        bus.cpu_addr   = caddr_s;
        bus.cpu_wrdata = cwdata_s;
        nclk++;
        #2;
        if (bus.video_strobe) begin
            n_vstb++;
            chk("vstb_latency", nclk - last_vnext_clk, 4);
            chk("vstb_data", bus.video_data, exp_vdata);
        end
        if (bus.cpu_strobe) begin
            n_cstb++;
            chk("cstb_latency", nclk - last_cnext_clk, 4);
            chk("cstb_data", bus.cpu_rddata, exp_cdata);
        end
        if (bus.dram_req) n_dreq++;
        if (ph == 3) begin
            if (bus.video_next) begin
                n_vnext++;
                if (!elig(bw_s, cend_idx)) n_bad++;
                chk("vnext_dram", {bus.dram_req, bus.dram_rnw, bus.dram_addr}, {1'b1, 1'b1, vaddr_s});
                last_vnext_clk = nclk;
                exp_vdata = model(vaddr_s);
                vaddr_s = vaddr_s + 1'b1;
            end
            if (bus.cpu_next) begin
                n_cnext++;
                chk("cnext_dram", {bus.dram_req, bus.dram_rnw, bus.dram_addr}, {1'b1, crnw_s, caddr_s});
                if (crnw_s) begin
                    last_cnext_clk = nclk;
                    exp_cdata = model(caddr_s);
                end
                caddr_s = caddr_s + 1'b1;
            end
            cend_idx++;
        end else if (bus.video_next || bus.cpu_next || bus.dram_req) begin
            n_bad++;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {bus.video_next, bus.video_strobe, bus.cpu_next, bus.cpu_strobe,
                            bus.dram_req, bus.dram_rnw}, 6'b0);
        chk({tag, "_addr"}, {bus.dram_addr, bus.dram_wrdata}, '0);
        chk({tag, "_data"}, {bus.video_data, bus.cpu_rddata}, '0);
    endtask

    initial begin
        int v0, c0, s0, cs0, d0;
        bit hit;
        logic [DATA_W-1:0] held;

        rst_s = 1'b0; go_s = 1'b1; bw_s = 2'b00; vaddr_s = 21'h00100;
        creq_s = 1'b1; crnw_s = 1'b1; caddr_s = 21'h02000; cwdata_s = '0;
        rst_n = 1'b0;
        bus.cbeg = 1'b0; bus.post_cbeg = 1'b0; bus.pre_cend = 1'b0; bus.cend = 1'b0;
        bus.video_go = 1'b0; bus.video_bw = 2'b00; bus.video_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b0; bus.cpu_addr = '0; bus.cpu_wrdata = '0;
        bus.dram_rddata = '0;

        // Reset held over two memory cycles with requests active: nothing may be granted.
        repeat (8) step();
        chk_outputs_zero("reset");

        // 1: 1/8 bandwidth, video only.
        creq_s = 1'b0; rst_s = 1'b1; cend_idx = 0;
        v0 = n_vnext; s0 = n_vstb; c0 = n_cnext;
        repeat (64) step();
        chk("t1_vnext", n_vnext - v0, 2);
        chk("t1_vstb", n_vstb - s0, 2);
        chk("t1_cnext", n_cnext - c0, 0);

        // 2: 4/8 bandwidth with CPU reads held.
        bw_s = 2'b10; creq_s = 1'b1; crnw_s = 1'b1;
        v0 = n_vnext; c0 = n_cnext;
        repeat (32) step();
        chk("t2_vnext", n_vnext - v0, 4);
        chk("t2_cnext", n_cnext - c0, 4);

        // 3: 2/8 bandwidth, video idle, CPU reads held.
        bw_s = 2'b01; go_s = 1'b0;
        v0 = n_vnext; c0 = n_cnext; d0 = n_dreq;
        repeat (32) step();
        chk("t3_vnext", n_vnext - v0, 0);
`ifdef ARB_CPU_BORROW_EN
        chk("t3_cnext", n_cnext - c0, 8);
        chk("t3_dreq", n_dreq - d0, 8);
`else
        chk("t3_cnext", n_cnext - c0, 6);
        chk("t3_dreq", n_dreq - d0, 6);
`endif

        // 4: single CPU write in a non-eligible slot.
        bw_s = 2'b00; creq_s = 1'b0;
        repeat (4) step();
        creq_s = 1'b1; crnw_s = 1'b0; caddr_s = 21'h1F000; cwdata_s = 16'hA55A;
        cs0 = n_cstb;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.cpu_next) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t4_grant", hit, 1'b1);
        chk("t4_dram", {bus.dram_req, bus.dram_rnw, bus.dram_addr, bus.dram_wrdata},
            {1'b1, 1'b0, 21'h1F000, 16'hA55A});
        creq_s = 1'b0;
        repeat (8) step();
        chk("t4_no_cstb", n_cstb - cs0, 0);

        // 5: reset between video_next and pre_cend abandons the read.
        go_s = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.video_next) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_wait_vnext", hit, 1'b1);
        s0 = n_vstb; v0 = n_vnext;
        rst_s = 1'b0;
        step();
        chk_outputs_zero("t5_reset");
        step();
        rst_s = 1'b1; cend_idx = -1;
        step();
        step();
        chk("t5_no_vstb", n_vstb - s0, 0);
        chk("t5_no_grant", n_vnext - v0, 0);
        repeat (4) step();
        chk("t5_slot0_vnext", n_vnext - v0, 1);
        chk("t5_vnext_now", bus.video_next, 1'b1);

        // 6: go drops the clock after video_next; the read still completes.
        go_s = 1'b0;
        s0 = n_vstb; v0 = n_vnext;
        repeat (4) step();
        chk("t6_vstb", n_vstb - s0, 1);
        held = exp_vdata;
        repeat (8) step();
        chk("t6_vnext", n_vnext - v0, 0);
        chk("t6_data_held", bus.video_data, held);

        chk("grant_placement", n_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
